// File: rtl/verdict_pkt_filter.sv
// verdict_pkt_filter: store-and-forward buffer that pairs each packet with
// its verdict, then drops it or forwards it with the verdict in tuser.
module verdict_pkt_filter #(
    parameter int DATA_W      = 256,
    localparam int KEEP_W     = DATA_W / 8,
    parameter int USER_W      = 12,
    parameter int ID_W        = 3,
    parameter int DEPTH       = 64,
    parameter int VQ_DEPTH    = 8,
    parameter int VERDICT_W   = 1,
    parameter bit DROP_MODE   = 1'b1
) (
    input  logic                 mlx2sbu_clk,
    input  logic                 mlx2sbu_reset,
    input  logic                 s_axis_vld,
    output logic                 s_axis_rdy,
    input  logic [DATA_W-1:0]    s_axis_tdata,
    input  logic [KEEP_W-1:0]    s_axis_tkeep,
    input  logic                 s_axis_tlast,
    input  logic                 verdict_vld,
    output logic                 verdict_rdy,
    input  logic [VERDICT_W-1:0] verdict_data,
    output logic                 m_axis_vld,
    input  logic                 m_axis_rdy,
    output logic [DATA_W-1:0]    m_axis_tdata,
    output logic [KEEP_W-1:0]    m_axis_tkeep,
    output logic                 m_axis_tlast,
    output logic [USER_W-1:0]    m_axis_tuser,
    output logic [ID_W-1:0]      m_axis_tid,
    output logic [31:0]          pass_cnt,
    output logic [31:0]          drop_cnt,
    output logic [31:0]          oversize_cnt
);
    localparam int AW  = $clog2(DEPTH);
    localparam int VAW = $clog2(VQ_DEPTH);
    localparam int BW  = DATA_W + KEEP_W + 1;
    localparam logic [AW:0]  P_ONE = 1;
    localparam logic [VAW:0] V_ONE = 1;

    typedef enum logic {W_WRITE, W_DISCARD} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_SEND, R_DROP} rstate_t;

    wstate_t wstate, wstate_nx;
    rstate_t rstate, rstate_nx;

    logic [BW-1:0]        mem [DEPTH];
    logic [VERDICT_W-1:0] vq_mem [VQ_DEPTH];
    logic [AW:0]          wr_ptr, commit_ptr, rd_ptr, pkt_cnt;
    logic [VAW:0]         vq_wr, vq_rd;
    logic [15:0]          skip_cnt;
    logic [VERDICT_W-1:0] cur_verdict, vq_head;
    logic [BW-1:0]        rd_word;
    logic full, oversize, discarding, s_fire, wr_en, commit;
    logic vq_empty, vq_full, vq_push, vq_pop;
    logic rd_en, rd_last, send_rd, pkt_dec, skip_dec;
    logic pass_inc, drop_inc, out_load;

    assign full = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A partial packet that alone fills the buffer can never complete.
    assign oversize   = (wstate == W_WRITE) && full &&
                        (wr_ptr != commit_ptr) && (pkt_cnt == '0);
    assign discarding = (wstate == W_DISCARD) || oversize;
    assign s_axis_rdy = ~mlx2sbu_reset & (~full | discarding);
    assign s_fire     = s_axis_vld & s_axis_rdy;
    assign wr_en      = s_fire & ~discarding;
    assign commit     = wr_en & s_axis_tlast;

    assign vq_empty    = vq_wr == vq_rd;
    assign vq_full     = (vq_wr[VAW] != vq_rd[VAW]) &&
                         (vq_wr[VAW-1:0] == vq_rd[VAW-1:0]);
    assign verdict_rdy = ~mlx2sbu_reset & ~vq_full;
    assign vq_push     = verdict_vld & verdict_rdy;
    assign vq_head     = vq_mem[vq_rd[VAW-1:0]];

    assign rd_word  = mem[rd_ptr[AW-1:0]];
    assign rd_last  = rd_word[0];
    assign out_load = ~m_axis_vld | m_axis_rdy;
    assign send_rd  = (rstate == R_SEND) && out_load;
    assign rd_en    = send_rd || (rstate == R_DROP);
    assign m_axis_tid = '0;

    always_comb begin
        wstate_nx = wstate;
        unique case (wstate)
            W_WRITE:
                if (oversize && !(s_fire && s_axis_tlast))
                    wstate_nx = W_DISCARD;
            W_DISCARD:
                if (s_fire && s_axis_tlast)
                    wstate_nx = W_WRITE;
        endcase
    end

    always_comb begin
        rstate_nx = rstate;
        vq_pop    = 1'b0;
        skip_dec  = 1'b0;
        pass_inc  = 1'b0;
        drop_inc  = 1'b0;
        pkt_dec   = 1'b0;
        unique case (rstate)
            R_IDLE: begin
                // Verdicts of discarded packets are consumed first.
                if (!vq_empty && skip_cnt != '0) begin
                    vq_pop   = 1'b1;
                    skip_dec = 1'b1;
                end else if (!vq_empty && pkt_cnt != '0) begin
                    vq_pop = 1'b1;
                    if (DROP_MODE && !vq_head[0]) begin
                        rstate_nx = R_DROP;
                        drop_inc  = 1'b1;
                    end else begin
                        rstate_nx = R_SEND;
                        pass_inc  = 1'b1;
                    end
                end
            end
            R_SEND, R_DROP: begin
                if (rd_en && rd_last) begin
                    pkt_dec   = 1'b1;
                    rstate_nx = R_IDLE;
                end
            end
            default: rstate_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge mlx2sbu_clk) begin
        if (wr_en)
            mem[wr_ptr[AW-1:0]] <= {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
        if (vq_push)
            vq_mem[vq_wr[VAW-1:0]] <= verdict_data;
    end

    always_ff @(posedge mlx2sbu_clk or posedge mlx2sbu_reset) begin
        if (mlx2sbu_reset) begin
            wstate       <= W_WRITE;
            rstate       <= R_IDLE;
            wr_ptr       <= '0;
            commit_ptr   <= '0;
            rd_ptr       <= '0;
            pkt_cnt      <= '0;
            skip_cnt     <= '0;
            vq_wr        <= '0;
            vq_rd        <= '0;
            cur_verdict  <= '0;
            pass_cnt     <= '0;
            drop_cnt     <= '0;
            oversize_cnt <= '0;
        end else begin
            wstate <= wstate_nx;
            rstate <= rstate_nx;
            if (oversize)
                wr_ptr <= commit_ptr;
            else if (wr_en)
                wr_ptr <= wr_ptr + P_ONE;
            if (commit)
                commit_ptr <= wr_ptr + P_ONE;
            if (rd_en)
                rd_ptr <= rd_ptr + P_ONE;
            if (commit && !pkt_dec)
                pkt_cnt <= pkt_cnt + P_ONE;
            else if (!commit && pkt_dec)
                pkt_cnt <= pkt_cnt - P_ONE;
            if (oversize && !skip_dec)
                skip_cnt <= skip_cnt + 16'd1;
            else if (!oversize && skip_dec)
                skip_cnt <= skip_cnt - 16'd1;
            if (vq_push)
                vq_wr <= vq_wr + V_ONE;
            if (vq_pop)
                vq_rd <= vq_rd + V_ONE;
            if (pass_inc)
                cur_verdict <= vq_head;
            if (pass_inc)
                pass_cnt <= pass_cnt + 32'd1;
            if (drop_inc)
                drop_cnt <= drop_cnt + 32'd1;
            if (oversize)
                oversize_cnt <= oversize_cnt + 32'd1;
        end
    end

    always_ff @(posedge mlx2sbu_clk or posedge mlx2sbu_reset) begin
        if (mlx2sbu_reset) begin
            m_axis_vld   <= 1'b0;
            m_axis_tdata <= '0;
            m_axis_tkeep <= '0;
            m_axis_tlast <= 1'b0;
            m_axis_tuser <= '0;
        end else if (send_rd) begin
            m_axis_vld   <= 1'b1;
            m_axis_tdata <= rd_word[BW-1:KEEP_W+1];
            m_axis_tkeep <= rd_word[KEEP_W:1];
            m_axis_tlast <= rd_last;
            m_axis_tuser <= USER_W'(cur_verdict);
        end else if (m_axis_rdy) begin
            m_axis_vld <= 1'b0;
        end
    end
endmodule
